// File: rtl/ddr3_cmd_sched_if.sv
// Host request and DDR3 command pin bundle for ddr3_cmd_sched.
interface ddr3_cmd_sched_if #(
  parameter int unsigned ROW_W = 14,
  parameter int unsigned COL_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_bank;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             cs_n;
  logic             ras_n;
  logic             cas_n;
  logic             we_n;
  logic [2:0]       ba;
  logic [ROW_W-1:0] addr;
  logic             ref_busy;

  modport master (
    output req_valid, req_we, req_bank, req_row, req_col,
    input  req_ready, cs_n, ras_n, cas_n, we_n, ba, addr, ref_busy
  );

  modport slave (
    input  req_valid, req_we, req_bank, req_row, req_col,
    output req_ready, cs_n, ras_n, cas_n, we_n, ba, addr, ref_busy
  );
endinterface

// File: rtl/ddr3_cmd_sched.sv
// DDR3 command scheduler: per-bank open-row tracking, PRE/ACT/RD/WR/REF spacing, periodic refresh.
// Optional macro DDR3_CLOSE_PAGE_EN: every access auto-precharges and no rows are kept open.
module ddr3_cmd_sched #(
  parameter int unsigned ROW_W  = 14,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned T_RCD  = 5,
  parameter int unsigned T_RP   = 5,
  parameter int unsigned T_CCD  = 4,
  parameter int unsigned T_RFC  = 44,
  parameter int unsigned T_REFI = 780
) (
  input logic             clk,
  input logic             reset,
  ddr3_cmd_sched_if.slave bus
);
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

`ifdef DDR3_CLOSE_PAGE_EN
  localparam int unsigned T_RW     = T_CCD + T_RP;
  localparam logic        AUTO_PRE = 1'b1;
`else
  localparam int unsigned T_RW     = T_CCD;
  localparam logic        AUTO_PRE = 1'b0;
`endif

  localparam int unsigned DLY_A   = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned DLY_B   = (T_RW > T_RFC) ? T_RW : T_RFC;
  localparam int unsigned DLY_MAX = (DLY_A > DLY_B) ? DLY_A : DLY_B;
  localparam int unsigned WAIT_W  = $clog2(DLY_MAX + 1);
  localparam int unsigned REF_W   = $clog2(T_REFI + 1);
  localparam int unsigned NBANK   = 8;
  localparam logic [ROW_W-1:0] A10 = ROW_W'(1) << 10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_ACT, ST_RW, ST_WAIT, ST_PREA, ST_REF
  } state_t;

  typedef struct packed {
    logic             we;
    logic [2:0]       bank;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } req_t;

  state_t             state_q, state_d, next_q, next_d, after;
  logic [WAIT_W-1:0]  wait_q, wait_d, dly;
  logic               go_wait;
  req_t               lat_q, lat_d;
  logic [NBANK-1:0]   open_q, open_d;
  logic [ROW_W-1:0]   rows_q [NBANK];
  logic [ROW_W-1:0]   rows_d [NBANK];
  logic [REF_W-1:0]   refcnt_q, refcnt_d;
  logic               pend_q, pend_d;
  logic               busy_q, busy_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [2:0]         ba_q, ba_d;
  logic [ROW_W-1:0]   addr_q, addr_d;
  logic               req_ready_c;

  assign req_ready_c = !reset && (state_q == ST_IDLE) && (wait_q == '0) && !pend_q;

  // Next-state, bookkeeping and the command that lands on the pins next cycle.
  always_comb begin
    state_d  = state_q;
    next_d   = next_q;
    wait_d   = wait_q;
    lat_d    = lat_q;
    open_d   = open_q;
    rows_d   = rows_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    go_wait  = 1'b0;
    dly      = '0;
    after    = ST_IDLE;
    cmd_d    = CMD_NOP;
    ba_d     = '0;
    addr_d   = '0;

    if (refcnt_q == REF_W'(1)) begin
      refcnt_d = REF_W'(T_REFI);
      pend_d   = 1'b1;
    end else begin
      refcnt_d = refcnt_q - REF_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          busy_d  = 1'b1;
          state_d = (|open_q) ? ST_PREA : ST_REF;
        end else if (bus.req_valid && req_ready_c) begin
          lat_d = {bus.req_we, bus.req_bank, bus.req_row, bus.req_col};
          if (!open_q[bus.req_bank])                   state_d = ST_ACT;
          else if (rows_q[bus.req_bank] == bus.req_row) state_d = ST_RW;
          else                                          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        open_d[lat_q.bank] = 1'b0;
        go_wait = 1'b1; dly = WAIT_W'(T_RP); after = ST_ACT;
      end
      ST_ACT: begin
`ifndef DDR3_CLOSE_PAGE_EN
        open_d[lat_q.bank] = 1'b1;
        rows_d[lat_q.bank] = lat_q.row;
`endif
        go_wait = 1'b1; dly = WAIT_W'(T_RCD); after = ST_RW;
      end
      ST_RW: begin
        go_wait = 1'b1; dly = WAIT_W'(T_RW); after = ST_IDLE;
      end
      ST_PREA: begin
        go_wait = 1'b1; dly = WAIT_W'(T_RP); after = ST_REF;
      end
      ST_REF: begin
        pend_d  = 1'b0;
        open_d  = '0;
        go_wait = 1'b1; dly = WAIT_W'(T_RFC); after = ST_IDLE;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_W'(1)) begin
          state_d = next_q;
          wait_d  = '0;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A one-clock spacing goes straight to the follow-up command.
    if (go_wait) begin
      if (dly == WAIT_W'(1)) begin
        state_d = after;
      end else begin
        state_d = ST_WAIT;
        wait_d  = dly - WAIT_W'(1);
        next_d  = after;
      end
    end

    if (state_d == ST_IDLE) busy_d = 1'b0;

    case (state_d)
      ST_ACT:  begin cmd_d = CMD_ACT; ba_d = lat_d.bank; addr_d = lat_d.row; end
      ST_PRE:  begin cmd_d = CMD_PRE; ba_d = lat_d.bank; end
      ST_RW: begin
        cmd_d  = lat_d.we ? CMD_WR : CMD_RD;
        ba_d   = lat_d.bank;
        addr_d = ROW_W'(lat_d.col) | (AUTO_PRE ? A10 : '0);
      end
      ST_PREA: begin cmd_d = CMD_PRE; addr_d = A10; end
      ST_REF:  cmd_d = CMD_REF;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      next_q   <= ST_IDLE;
      wait_q   <= '0;
      lat_q    <= '0;
      open_q   <= '0;
      rows_q   <= '{default: '0};
      refcnt_q <= REF_W'(T_REFI);
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      cmd_q    <= CMD_NOP;
      ba_q     <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      next_q   <= next_d;
      wait_q   <= wait_d;
      lat_q    <= lat_d;
      open_q   <= open_d;
      rows_q   <= rows_d;
      refcnt_q <= refcnt_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      cmd_q    <= cmd_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
    end
  end

  assign {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = cmd_q;
  assign bus.ba        = ba_q;
  assign bus.addr      = addr_q;
  assign bus.ref_busy  = busy_q;
  assign bus.req_ready = req_ready_c;
endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// Scoreboard bench for ddr3_cmd_sched: expected commands queued at accept, checked by a pin monitor.
module tb_ddr3_cmd_sched;
  localparam int unsigned ROW_W = 14, COL_W = 10;
  localparam int unsigned T_RCD = 5, T_RP = 5, T_CCD = 4, T_RFC = 44, T_REFI = 780;
  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001;
  localparam logic [ROW_W-1:0] A10 = 14'h0400;
  localparam int K_HIT = 0, K_CLOSED = 1, K_MISS = 2, K_ABORT = 3;

  typedef struct {
    int               cyc;
    logic [3:0]       cmd;
    logic [2:0]       ba;
    logic [ROW_W-1:0] addr;
  } exp_t;

  exp_t sb[$];
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   ref_end  = -10;

  ddr3_cmd_sched_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  ddr3_cmd_sched #(
    .ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD), .T_RP(T_RP),
    .T_CCD(T_CCD), .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input logic [3:0] cmd, input logic [2:0] ba,
                               input logic [ROW_W-1:0] a);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.ba = ba; e.addr = a;
    sb.push_back(e);
  endfunction

  // Pin monitor: every non-NOP command must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:0] c;
    exp_t e;
    c = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};
    if (c == C_NOP) begin
      chk("nop_ba_addr", 32'({bus.ba, bus.addr}), 32'd0);
    end else if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_cmd: got cmd=%b ba=%0d addr=0x%0h expected none (cycle %0d)",
               c, bus.ba, bus.addr, cyc);
    end else begin
      e = sb.pop_front();
      chk("cmd_cycle", 32'(cyc), 32'(e.cyc));
      chk("cmd_code", 32'(c), 32'(e.cmd));
      chk("cmd_ba", 32'(bus.ba), 32'(e.ba));
      chk("cmd_addr", 32'(bus.addr), 32'(e.addr));
      if (c == C_REF) ref_end = cyc + T_RFC - 1;
      if (c == C_REF || (c == C_PRE && bus.addr[10])) chk("ref_busy_cmd", 32'(bus.ref_busy), 32'd1);
    end
    if (bus.ref_busy) chk("ready_while_busy", 32'(bus.req_ready), 32'd0);
    if (cyc == ref_end)     chk("ref_busy_last", 32'(bus.ref_busy), 32'd1);
    if (cyc == ref_end + 1) chk("ref_busy_drop", 32'(bus.ref_busy), 32'd0);
  end

  task automatic wait_cyc(input int target);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (cyc < target && i < 5000);
    chk("wait_target", 32'(cyc), 32'(target));
  endtask

  task automatic do_reset(output int r0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cmd", 32'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n}), 32'(C_NOP));
    chk("rst_ba_addr", 32'({bus.ba, bus.addr}), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_ref_busy", 32'(bus.ref_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    r0 = cyc;
    #1;
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [2:0] bank, input logic [ROW_W-1:0] row,
                        input logic [COL_W-1:0] col, input int kind, input int exp_acc,
                        output int rw_cyc);
    int n;
    bit got;
    logic [3:0] rw;
    logic [ROW_W-1:0] ca;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_bank = bank;
      bus.req_row = row; bus.req_col = col;
      #1;
      if (bus.req_ready) begin got = 1'b1; n = cyc; end
    end
    if (!got) begin
      bus.req_valid = 1'b0;
      checks++; failures++;
      $display("FAIL req_timeout: got no req_ready expected accept by cycle %0d (cycle %0d)", exp_acc, cyc);
      rw_cyc = cyc;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("accept_cycle", 32'(n), 32'(exp_acc));
    rw = we ? C_WR : C_RD;
    ca = ROW_W'(col);
    case (kind)
      K_HIT: begin
        push(n + 1, rw, bank, ca);
        rw_cyc = n + 1;
      end
      K_MISS: begin
        push(n + 1, C_PRE, bank, '0);
        push(n + 1 + T_RP, C_ACT, bank, row);
        push(n + 1 + T_RP + T_RCD, rw, bank, ca);
        rw_cyc = n + 1 + T_RP + T_RCD;
      end
      K_ABORT: begin
        push(n + 1, C_ACT, bank, row);
        rw_cyc = n + 1 + T_RCD;
      end
      default: begin
        push(n + 1, C_ACT, bank, row);
        push(n + 1 + T_RCD, rw, bank, ca);
        rw_cyc = n + 1 + T_RCD;
      end
    endcase
  endtask

  initial begin
    int r0, r1, m, p, n6;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_bank = '0;
    bus.req_row = '0; bus.req_col = '0;

    do_reset(r0);
    do_req(1'b0, 3'd2, 14'h01A3, 10'h040, K_CLOSED, r0 + 1, m);
    do_req(1'b1, 3'd2, 14'h01A3, 10'h155, K_HIT, m + T_CCD, m);
    do_req(1'b0, 3'd2, 14'h01A4, 10'h3FF, K_MISS, m + T_CCD, m);
    do_req(1'b1, 3'd7, 14'h3FFF, 10'h000, K_CLOSED, m + T_CCD, m);

    // Refresh with banks 2 and 7 open; a request arrives the cycle ref_pending rises.
    p = r0 + T_REFI + 1;
    push(p, C_PRE, 3'd0, A10);
    push(p + T_RP, C_REF, 3'd0, '0);
    wait_cyc(p - 2);
    do_req(1'b0, 3'd2, 14'h01A3, 10'h010, K_CLOSED, p + T_RP + T_RFC, m);

    // Reset lands inside the T_RCD wait: the pending RD must never appear.
    do_req(1'b0, 3'd5, 14'h00AA, 10'h020, K_ABORT, m + T_CCD, m);
    n6 = m - 1 - T_RCD;
    wait_cyc(n6 + 2);
    do_reset(r1);
    do_req(1'b0, 3'd5, 14'h00AA, 10'h020, K_CLOSED, r1 + 1, m);
    do_req(1'b0, 3'd2, 14'h01A3, 10'h010, K_CLOSED, m + T_CCD, m);

    wait_cyc(m + T_CCD + 10);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
